demux_1_to_8_reg: RTL and testbench
===================================

// Module: demux_1_to_8_reg
// PURPOSE
//  Registered 1-to-8 write distributor: the write-side counterpart of the 8-to-1 read mux.
//  - Accepts one WIDTH-bit word per cycle via valid/ready.
//  - Steers the word into one of 8 holding slots selected by in_sel.
//  - Each slot presents data + valid to its consumer until acknowledged.
//  - Sits between the factorial datapath result bus and the 8 register/consumer ports.
// PARAMETERS
//  WIDTH  32  data width of the input word and of each slot
// PORTS
//  clk        in   1         single clock, rising edge
//  reset_n    in   1         asynchronous, active-low reset
//  in_valid   in   1         producer has a word on in_data/in_sel
//  in_ready   out  1         block can accept the word this cycle
//  in_sel     in   3         target slot 0..7 (3'b000=slot a ... 3'b111=slot h)
//  in_data    in   WIDTH     word to store
//  out_data   out  8*WIDTH   slot k occupies bits [k*WIDTH +: WIDTH]
//  out_valid  out  8         slot k holds unconsumed data
//  out_ack    in   8         consumer k takes slot k's data this cycle
//  occ_cnt    out  4         number of occupied slots, 0..8
// BEHAVIOUR
//  Reset: reset_n low clears out_valid, out_data, occ_cnt to 0 immediately, independent of clk.
//   Words in flight are lost; no accept occurs while reset_n is low.
//  Per-slot FSM, 2 states:
//   EMPTY -> FULL on accept to that slot.
//   FULL -> EMPTY on out_ack[k].
//   out_valid[k] = (state==FULL).
//  Ready rule:
//   in_ready = ~out_valid[in_sel], combinational from registered state and in_sel only.
//   No comb path from out_ack to in_ready.
//  Accept: accept = in_valid & in_ready. On the accepting edge, slot[in_sel] <= in_data and out_valid[in_sel] <= 1.
//  Latency: data and valid are visible on the outputs 1 cycle after the accept edge.
//  Producer rule: in_valid held with in_sel/in_data stable until accepted. in_sel changing while stalled is legal.
//   in_ready follows the new in_sel.
//  Ack rules:
//   - out_ack[k] with out_valid[k]=0 is ignored (no state change, no count change).
//   - Several acks in one cycle are all honoured.
//  out_data[k] is not cleared on ack; it holds its last value until overwritten or reset.
//  Simultaneous events:
//   - Ack of slot k while in_sel=k: in_ready stays 0 that cycle. The write is accepted at the earliest the next cycle.
//   - Write to slot j while acks arrive on other slots: both take effect.
//   - occ_cnt_next = occ_cnt + accept - popcount(out_ack & out_valid).
//  occ_cnt never exceeds 8 or goes below 0 by construction. The bench asserts this.
// CONFIGURATION
//  DEMUX_BCAST_EN defined:
//   - Adds input port in_bcast (1 bit).
//   - With in_bcast=1: in_ready = ~|out_valid (all slots empty). in_sel is ignored.
//   - Accept writes in_data to all 8 slots and sets out_valid=8'hFF. occ_cnt becomes 8.
//   - in_bcast=0 behaves exactly as the undefined case.
//  DEMUX_BCAST_EN undefined: no in_bcast port; single-slot writes only.
// TESTING
//  1. Reset low mid-traffic with slots 2,5 FULL -> out_valid=0, out_data=0, occ_cnt=0 with no clk edge.
//  2. Write in_sel=3, in_data=32'hDEADBEEF, no ack -> next cycle out_valid=8'h08, slot3=DEADBEEF, occ_cnt=1.
//     Second write to sel 3 -> in_ready=0, stalls.
//  3. Slot 3 FULL, out_ack=8'h08 while in_valid with in_sel=3, data 32'h5 -> that cycle in_ready=0.
//     Next cycle accepted; slot3=5 one cycle later; occ_cnt 1->0->1.
//  4. Fill slots 0..7 with data k+1 in 8 back-to-back cycles -> in_ready=1 every cycle, occ_cnt=8.
//     Then out_ack=8'hFF -> out_valid=0, occ_cnt=0, out_data unchanged.
//  5. out_ack=8'h81 on empty slots -> no change. Slot1 FULL + write sel 4 + out_ack=8'h02 in one cycle -> out_valid=8'h10, occ_cnt=1.
//  6. (DEMUX_BCAST_EN) in_bcast=1, data 32'hA5A5A5A5, all empty -> next cycle all slots A5A5A5A5, out_valid=8'hFF.
//     Repeat with any slot FULL -> in_ready=0.

Source files
------------

// File: rtl/demux_1_to_8_reg.sv
// ============================================================================
// Module      : demux_1_to_8_reg
// Description : Registered 1-to-8 write distributor. One WIDTH-bit word per
//               cycle is taken over a valid/ready handshake and parked in one
//               of eight holding slots chosen by in_sel. Each slot presents
//               its data with a valid flag until its consumer acknowledges.
// Config macro: DEMUX_BCAST_EN - adds in_bcast; a broadcast write fills all
//               eight slots at once and is only accepted when all are empty.
// Ports       :
//   clk        in   1         clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   in_valid   in   1         producer presents a word
//   in_ready   out  1         word can be accepted this cycle
//   in_sel     in   3         target slot 0..7
//   in_data    in   WIDTH     word to store
//   in_bcast   in   1         (DEMUX_BCAST_EN only) write to all slots
//   out_data   out  8*WIDTH   slot k at [k*WIDTH +: WIDTH]
//   out_valid  out  8         slot k holds unconsumed data
//   out_ack    in   8         consumer k takes slot k this cycle
//   occ_cnt    out  4         number of occupied slots, 0..8
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1_to_8_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
`ifdef DEMUX_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic [8*WIDTH-1:0] out_data,
  output logic [7:0]         out_valid,
  input  logic [7:0]         out_ack,
  output logic [3:0]         occ_cnt
);

  localparam int c_SLOTS = 8;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state     [c_SLOTS];
  state_t           w_state_nxt [c_SLOTS];
  logic [WIDTH-1:0] r_data      [c_SLOTS];
  logic [3:0]       r_occ;
  logic [3:0]       w_occ_nxt;
  logic [3:0]       w_ack_cnt;
  logic [3:0]       w_add;
  logic [7:0]       w_wr;
  logic [7:0]       w_pop;
  logic             w_bcast;
  logic             w_ready;
  logic             w_accept;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // Ready depends only on registered slot state and the selection, so an
  // ack landing on the selected slot cannot open the door in the same cycle.
  assign w_ready  = w_bcast ? ~|out_valid : ~out_valid[in_sel];
  assign w_accept = in_valid & w_ready;
  assign in_ready = w_ready;
  assign occ_cnt  = r_occ;

  // A write only reaches an EMPTY slot and an effective ack only a FULL one,
  // so the two never collide on the same slot.
  always_comb begin
    w_ack_cnt = 4'd0;
    for (int k = 0; k < c_SLOTS; k++) begin
      w_wr[k]        = w_accept & (w_bcast | (in_sel == 3'(k)));
      w_pop[k]       = out_ack[k] & (r_state[k] == S_FULL);
      w_ack_cnt      = w_ack_cnt + {3'b000, w_pop[k]};
      w_state_nxt[k] = r_state[k];
      if (w_wr[k]) begin
        w_state_nxt[k] = S_FULL;
      end else if (w_pop[k]) begin
        w_state_nxt[k] = S_EMPTY;
      end
    end
    if (w_accept) begin
      w_add = w_bcast ? 4'd8 : 4'd1;
    end else begin
      w_add = 4'd0;
    end
    w_occ_nxt = r_occ + w_add - w_ack_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ <= 4'd0;
      for (int k = 0; k < c_SLOTS; k++) begin
        r_state[k] <= S_EMPTY;
        r_data[k]  <= '0;
      end
    end else begin
      r_occ <= w_occ_nxt;
      for (int k = 0; k < c_SLOTS; k++) begin
        r_state[k] <= w_state_nxt[k];
        // Data is kept after an ack; only a new write replaces it.
        if (w_wr[k]) begin
          r_data[k] <= in_data;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < c_SLOTS; g++) begin : g_slot
      assign out_valid[g]                = (r_state[g] == S_FULL);
      assign out_data[g*WIDTH +: WIDTH]  = r_data[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_demux_1_to_8_reg.sv
// ============================================================================
// Module      : tb_demux_1_to_8_reg
// Description : Directed self-checking bench for demux_1_to_8_reg. Inputs
//               change 1 time unit after the rising edge; outputs are
//               sampled after that. Broadcast steps build only when
//               DEMUX_BCAST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1_to_8_reg;

  localparam int WIDTH = 32;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
`ifdef DEMUX_BCAST_EN
  logic               in_bcast;
`endif
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ack;
  logic [3:0]         occ_cnt;

  int tests;
  int fails;
  logic [8*WIDTH-1:0] exp_data;

  demux_1_to_8_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occ_cnt   (occ_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must always equal the number of valid slots and stay within 0..8.
  always @(negedge clk) begin
    if (reset_n) begin
      tests++;
      assert ((occ_cnt <= 4'd8) && (32'(occ_cnt) == $countones(out_valid))) else begin
        fails++;
        $error("FAIL occ_consistency observed=%0d expected=%0d", occ_cnt, $countones(out_valid));
      end
    end
  end

  initial begin
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_sel   = 3'd0;
    in_data  = '0;
    out_ack  = 8'h00;
`ifdef DEMUX_BCAST_EN
    in_bcast = 1'b0;
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("reset_valid", 256'(out_valid), 256'(8'h00));
    chk("reset_occ",   256'(occ_cnt),   256'(4'd0));
    chk("reset_data",  256'(out_data),  256'(0));
    #9 reset_n = 1'b1;
    tick();

    // Single write to slot 3, then a stalled second write.
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF;
    #1 chk("t2_ready_empty", 256'(in_ready), 256'(1'b1));
    tick();
    in_data = 32'h12345678;
    #1;
    chk("t2_valid", 256'(out_valid), 256'(8'h08));
    chk("t2_slot3", 256'(out_data[3*WIDTH +: WIDTH]), 256'(32'hDEADBEEF));
    chk("t2_occ",   256'(occ_cnt), 256'(4'd1));
    chk("t2_ready_full", 256'(in_ready), 256'(1'b0));
    tick();
    chk("t2_stall_slot3", 256'(out_data[3*WIDTH +: WIDTH]), 256'(32'hDEADBEEF));

    // Ack on the selected slot does not raise in_ready in the same cycle.
    in_data = 32'h5; out_ack = 8'h08;
    #1 chk("t3_ready_ack", 256'(in_ready), 256'(1'b0));
    tick();
    out_ack = 8'h00;
    #1;
    chk("t3_occ_after_ack", 256'(occ_cnt), 256'(4'd0));
    chk("t3_valid_after_ack", 256'(out_valid), 256'(8'h00));
    chk("t3_ready_next", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("t3_slot3", 256'(out_data[3*WIDTH +: WIDTH]), 256'(32'h5));
    chk("t3_occ",   256'(occ_cnt), 256'(4'd1));
    out_ack = 8'h08;
    tick();
    out_ack = 8'h00;
    chk("t3_drain_occ", 256'(occ_cnt), 256'(4'd0));

    // Fill all eight slots back-to-back.
    exp_data = '0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_sel = 3'(k); in_data = 32'(k + 1);
      exp_data[k*WIDTH +: WIDTH] = 32'(k + 1);
      #1 chk("t4_ready_fill", 256'(in_ready), 256'(1'b1));
      tick();
    end
    in_valid = 1'b0;
    chk("t4_valid_full", 256'(out_valid), 256'(8'hFF));
    chk("t4_occ_full",   256'(occ_cnt),   256'(4'd8));
    chk("t4_data",       256'(out_data),  256'(exp_data));
    out_ack = 8'hFF;
    tick();
    out_ack = 8'h00;
    chk("t4_valid_drained", 256'(out_valid), 256'(8'h00));
    chk("t4_occ_drained",   256'(occ_cnt),   256'(4'd0));
    chk("t4_data_kept",     256'(out_data),  256'(exp_data));

    // Acks on empty slots are ignored; write and ack on different slots coexist.
    out_ack = 8'h81;
    tick();
    out_ack = 8'h00;
    chk("t5_spurious_valid", 256'(out_valid), 256'(8'h00));
    chk("t5_spurious_occ",   256'(occ_cnt),   256'(4'd0));
    in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h11;
    tick();
    in_sel = 3'd4; in_data = 32'h44; out_ack = 8'h02;
    tick();
    in_valid = 1'b0; out_ack = 8'h00;
    chk("t5_valid", 256'(out_valid), 256'(8'h10));
    chk("t5_occ",   256'(occ_cnt),   256'(4'd1));
    chk("t5_slot4", 256'(out_data[4*WIDTH +: WIDTH]), 256'(32'h44));

    // Asynchronous reset mid-traffic with slots 2 and 5 occupied.
    out_ack = 8'h10;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h22;
    tick();
    out_ack = 8'h00; in_sel = 3'd5; in_data = 32'h55;
    tick();
    in_sel = 3'd6; in_data = 32'h66;
    chk("t1_pre_valid", 256'(out_valid), 256'(8'h24));
    #2 reset_n = 1'b0;
    #1;
    chk("t1_valid", 256'(out_valid), 256'(8'h00));
    chk("t1_occ",   256'(occ_cnt),   256'(4'd0));
    chk("t1_data",  256'(out_data),  256'(0));
    tick();
    chk("t1_no_accept", 256'(out_valid), 256'(8'h00));
    in_valid = 1'b0;
    #1 reset_n = 1'b1;
    tick();

`ifdef DEMUX_BCAST_EN
    // Broadcast into an all-empty block, then refused while any slot is full.
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd2; in_data = 32'hA5A5A5A5;
    #1 chk("t6_ready_empty", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("t6_valid", 256'(out_valid), 256'(8'hFF));
    chk("t6_occ",   256'(occ_cnt),   256'(4'd8));
    chk("t6_data",  256'(out_data),  {8{32'hA5A5A5A5}});
    out_ack = 8'hFE;
    tick();
    out_ack = 8'h00;
    in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h1;
    #1 chk("t6_ready_busy", 256'(in_ready), 256'(1'b0));
    tick();
    in_valid = 1'b0; in_bcast = 1'b0;
    chk("t6_no_write", 256'(out_valid), 256'(8'h01));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
